mul_arbiter: RTL
================

Name: mul_arbiter

Overview:
- Shares one pipelined multiplier (generic_mul style: free-running, no enable, fixed latency) between NREQ requesters, typically HLS-generated datapaths.
- Round-robin arbitration; at most one operation issued per cycle.
- Tracks the owner of each in-flight operation with a tag/valid shift line matched to the multiplier latency, and routes each product back to its requester.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 32: operand width; product is 2*WIDTH.
- LATENCY, 5: cycles from mul_a/mul_b presented to mul_pdt valid (generic_mul level=4 gives 5).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant (combinational, one-hot or zero).
- req_a  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- resp_valid  out  NREQ  one-hot result strobe, registered.
- resp_data  out  2*WIDTH  product, shared by all requesters, registered.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_pdt  in  2*WIDTH  product from the multiplier.
- issue_count  out  32  perf counter (optional feature).
- conflict_count  out  32  perf counter (optional feature).

Behaviour:
- Reset (rst=1 at posedge): rr_ptr=0, all tag-line valids=0, resp_valid=0, resp_data=0, counters=0.
- In-flight operations at reset are dropped; no resp_valid is ever produced for them.
- Arbitration (combinational):
  - Search starts at index rr_ptr+1 mod NREQ and wraps; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - All other req_ready bits are 0. No requester valid -> req_ready=0.
  - req_ready never depends on req_a/req_b.
- Issue:
  - Accept = req_valid[i] & req_ready[i].
  - mul_a/mul_b = req_a/req_b of the granted requester; 0 when no grant.
  - On accept: rr_ptr <= i at the posedge. With no accept, rr_ptr holds.
- Requesters must hold req_valid and operands stable until accepted. Back-to-back accepts from the same requester are allowed when it is the sole requester.
- Tag line:
  - LATENCY-stage shift register of {valid, id[$clog2(NREQ)-1:0]}.
  - Stage 0 loads {accept, granted id} each cycle; shifts unconditionally every cycle.
- Response:
  - When the last stage is valid, resp_data <= mul_pdt and resp_valid <= onehot(id) at the next posedge. Otherwise resp_valid <= 0 and resp_data holds.
  - Total latency from the accept edge to resp_valid high = LATENCY+1 cycles.
  - resp_valid is high for exactly one cycle.
- No response backpressure: requesters must consume resp_data in the cycle resp_valid is high.
- Throughput: one op per cycle sustained; N ops in flight with N <= LATENCY+1.
- Fairness: with all NREQ valid continuously, grants rotate i, i+1, ...; each requester waits at most NREQ-1 cycles.
- Arithmetic: unsigned multiply; no truncation inside this block. Width selection is done by the requester.
- A requester dropping req_valid while not granted is allowed (no accept occurs). Dropping it while granted in the same cycle means no accept, because accept is evaluated combinationally.

Optional Feature:
- Macro: MULARB_PERF_EN.
- Defined:
  - issue_count increments on every accept.
  - conflict_count increments on each cycle where popcount(req_valid) >= 2.
  - Both are 32-bit, wrap 0xFFFFFFFF -> 0, and clear on rst.
- Undefined: both ports are tied to 0; no counter flops are inferred.

Test Plan:
- Single op: req 2 valid, a=7, b=6, others idle -> req_ready=4'b0100 that cycle; resp_valid=4'b0100, resp_data=42 exactly LATENCY+1 cycles later; one-cycle pulse.
- Full contention: all 4 valid from rr_ptr=0, distinct operands (a=i+1, b=10) -> grants in order 1,2,3,0,1,...; responses 20,30,40,10 return in grant order, each with the matching one-hot resp_valid.
- Back-to-back: req 0 alone issues 8 ops a=k, b=k (k=1..8) on consecutive cycles -> 8 consecutive resp_valid=4'b0001 with 1,4,9,...,64; no gaps.
- Wide operands: a=b=0xFFFFFFFF -> resp_data=0xFFFFFFFE00000001.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle 2 cycles later -> no resp_valid afterwards; rr_ptr=0, so the next contention grant goes to req 1.
- MULARB_PERF_EN: 10 accepts, 4 cycles with 2+ valid -> issue_count=10, conflict_count=4. Without the macro, both read 0.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among NREQ requesters.
// Define MULARB_PERF_EN to enable the issue/conflict performance counters.
module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]      resp_data,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_pdt,
  output logic [31:0]             issue_count,
  output logic [31:0]             conflict_count
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][IDW-1:0]   id_pipe_q, id_pipe_d;
  logic [NREQ-1:0]               resp_valid_q, resp_valid_d;
  logic [2*WIDTH-1:0]            resp_data_q, resp_data_d;

  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic           accept;

  // Search begins one past the last winner so the previous owner goes last.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    accept    = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!accept && req_valid[idx]) begin
        accept = 1'b1;
        gnt_id = idx;
      end
    end
    req_ready[gnt_id] = accept;
  end

  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      mul_a    = req_a[gnt_id*WIDTH +: WIDTH];
      mul_b    = req_b[gnt_id*WIDTH +: WIDTH];
      rr_ptr_d = gnt_id;
    end
  end

  // Owner tags travel alongside the multiplier pipeline; the tail lines up with mul_pdt.
  always_comb begin
    vld_pipe_d    = '0;
    id_pipe_d     = '0;
    vld_pipe_d[0] = accept;
    id_pipe_d[0]  = gnt_id;
    for (int k = 1; k < LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      id_pipe_d[k]  = id_pipe_q[k-1];
    end
  end

  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (vld_pipe_q[LATENCY-1]) begin
      resp_valid_d[id_pipe_q[LATENCY-1]] = 1'b1;
      resp_data_d                        = mul_pdt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      vld_pipe_q   <= '0;
      id_pipe_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      vld_pipe_q   <= vld_pipe_d;
      id_pipe_q    <= id_pipe_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

`ifdef MULARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    issue_cnt_d    = issue_cnt_q + {31'd0, accept};
    conflict_cnt_d = conflict_cnt_q;
    if ($countones(req_valid) >= 2) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      issue_cnt_q    <= issue_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign issue_count    = issue_cnt_q;
  assign conflict_count = conflict_cnt_q;
`else
  assign issue_count    = '0;
  assign conflict_count = '0;
`endif

endmodule
